pixel_sensor_controller: RTL
============================

Name: pixel_sensor_controller

Overview:
- Digital frame sequencer that drives the pixel array's ERASE, EXPOSE and RAMP lines.
- Broadcasts the conversion count value to the array.
- Walks the rows out to the readout stage with a valid/ready handshake.
- Sits directly upstream of every pixel sensor instance (analog + digital latch) and downstream of the top-level frame trigger.

Parameters:
- PIXEL_BITS, 8, ADC resolution; CONVERT issues 2**PIXEL_BITS RAMP pulses.
- ROWS, 24, number of pixel rows; width of ROW_SEL.
- ERASE_CYCLES, 5, clk cycles ERASE is held high (must be ≥1).
- EXPOSE_CYCLES, 255, clk cycles EXPOSE is held high (must be ≥1).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  frame request, sampled only in IDLE.
- ERASE  out  1  pixel erase strobe.
- EXPOSE  out  1  pixel exposure enable.
- RAMP  out  1  conversion ramp pulse train.
- COUNTER  out  PIXEL_BITS  count value broadcast to pixel latches.
- ROW_SEL  out  ROWS  one-hot row read select.
- row_valid  out  1  selected row data is valid for readout.
- row_ready  in  1  readout accepts the current row.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0: ERASE, EXPOSE, RAMP, COUNTER, ROW_SEL, row_valid, busy, frame_done. Internal timers cleared. Reset may arrive mid-frame; the frame is abandoned with no partial frame_done.
- Every output is registered; no combinational path from start or row_ready to any output.
- States: IDLE -> ERASE -> EXPOSE -> CONVERT -> READ -> IDLE.
- IDLE:
  - start=1 at edge n -> ERASE state.
  - ERASE=1 and busy=1 from cycle n+1.
  - start is ignored in all other states; no queuing.
- ERASE: ERASE=1 for exactly ERASE_CYCLES cycles, then EXPOSE state with ERASE=0 and EXPOSE=1 on the same cycle (no gap, no overlap).
- EXPOSE: EXPOSE=1 for exactly EXPOSE_CYCLES cycles, then CONVERT state with EXPOSE=0.
- CONVERT:
  - Lasts 2*2**PIXEL_BITS cycles in a 2-cycle phase: even cycle RAMP=0, odd cycle RAMP=1.
  - The first CONVERT cycle has RAMP=0.
  - During pulse k (k=0..2**PIXEL_BITS-1), COUNTER=k and is stable across both cycles of that phase.
  - COUNTER increments on the cycle after each RAMP high, except after the last pulse: it holds 2**PIXEL_BITS-1 with no wrap.
- READ:
  - Entry cycle: ROW_SEL=1<<0, row_valid=1, COUNTER held.
  - A transfer occurs on any edge where row_valid&&row_ready. The next cycle then selects row r+1 (ROW_SEL shifts left by one), with row_valid remaining 1.
  - row_ready low stalls indefinitely; ROW_SEL and row_valid hold.
  - Transfer of row ROWS-1: next cycle is IDLE with ROW_SEL=0, row_valid=0, busy=0, frame_done=1 for one cycle, COUNTER=0.
- start=1 in the same cycle frame_done=1: accepted (state is IDLE), so ERASE=1 on the following cycle.
- Total frame latency with row_ready tied high: ERASE_CYCLES + EXPOSE_CYCLES + 2*2**PIXEL_BITS + ROWS cycles from the first busy cycle to frame_done.
- Width rules:
  - Timer width is $clog2 of the largest of ERASE_CYCLES, EXPOSE_CYCLES and 2*2**PIXEL_BITS, plus 1.
  - Row index width is $clog2(ROWS).
  - All comparisons are done at explicit widths.

Decomposition:
- Shared package PixelSensorConfig additions:
  - State enum typedef sensor_state_t {IDLE, ERASE, EXPOSE, CONVERT, READ}.
  - Default constants ERASE_CYCLES and EXPOSE_CYCLES.
  - PIXEL_BITS and ROWS default from the existing PIXEL_BITS and PIXEL_ARRAY_HEIGHT.
- One sub-module, pixel_sensor_phase_timer:
  - Loadable down-counter with async active-high reset.
  - Ports: load, load_value, expired.
  - Used for the ERASE, EXPOSE and CONVERT durations.
- The FSM, RAMP phase, COUNTER and row shifter live in the top module.

Test Plan:
- Reset then start pulse at cycle 10, row_ready=1 -> ERASE high cycles 11-15; EXPOSE high cycles 16-270; first RAMP=1 at cycle 272; 256 RAMP pulses; frame_done at cycle 11+5+255+512+24=807.
- CONVERT monitor -> during pulse k COUNTER==k for k=0..255; COUNTER stays 255 after the last pulse, never 0 before READ.
- READ with row_ready low for 7 cycles at row 3 -> ROW_SEL=0x000008 and row_valid=1 held for all 7 cycles; row 4 is selected on the cycle after row_ready rises; all 24 rows are seen exactly once, in order.
- start asserted during EXPOSE and during READ -> no state change, no restart; start coincident with frame_done -> ERASE=1 on the next cycle.
- Async reset asserted mid-CONVERT (pulse 100), between clock edges -> all outputs 0 immediately; no frame_done; a new start after release produces a full, correct frame.
- Instantiate 24x24 PIXEL_SENSOR_ANALOG models fed by ERASE/RAMP; latch COUNTER on CMP rise -> each latched value equals 255-SCENE_24 pixel value ±1 pulse.

Source files
------------

// File: rtl/pixel_sensor_controller_pkg.sv
// Shared configuration for the pixel array frame sequencer: defaults, FSM state
// encoding and timer sizing helpers.
package pixel_sensor_controller_pkg;

    localparam int PIXEL_BITS_DEFAULT  = 8;
    localparam int PIXEL_ARRAY_HEIGHT  = 24;

    localparam int DEF_PIXEL_BITS    = PIXEL_BITS_DEFAULT;
    localparam int DEF_ROWS          = PIXEL_ARRAY_HEIGHT;
    localparam int DEF_ERASE_CYCLES  = 5;
    localparam int DEF_EXPOSE_CYCLES = 255;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_EXPOSE  = 3'd2,
        S_CONVERT = 3'd3,
        S_READ    = 3'd4
    } sensor_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One spare bit so a load value equal to the largest duration never wraps.
    function automatic int timer_width(input int erase_cycles, input int expose_cycles,
                                       input int pixel_bits);
        return $clog2(max3(erase_cycles, expose_cycles, 2 * (2 ** pixel_bits))) + 1;
    endfunction

endpackage

// File: rtl/pixel_sensor_controller_phase_timer.sv
// Loadable down-counter timing the ERASE, EXPOSE and CONVERT phases; expired
// is high whenever the count has reached zero.
module pixel_sensor_phase_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/pixel_sensor_controller.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion with a
// broadcast count, then a row-by-row valid/ready readout.
//
// state   | meaning
// IDLE    | waiting for start; all strobes low
// ERASE   | ERASE held high for ERASE_CYCLES
// EXPOSE  | EXPOSE held high for EXPOSE_CYCLES
// CONVERT | RAMP toggles every cycle, COUNTER advances after each high phase
// READ    | one-hot ROW_SEL walks the rows as the readout accepts them
module pixel_sensor_controller
    import pixel_sensor_controller_pkg::*;
#(
    parameter int PIXEL_BITS    = DEF_PIXEL_BITS,
    parameter int ROWS          = DEF_ROWS,
    parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES,
    parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ERASE,
    output logic                  EXPOSE,
    output logic                  RAMP,
    output logic [PIXEL_BITS-1:0] COUNTER,
    output logic [ROWS-1:0]       ROW_SEL,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CONVERT_CYCLES = 2 * (2 ** PIXEL_BITS);
    localparam int TW = timer_width(ERASE_CYCLES, EXPOSE_CYCLES, PIXEL_BITS);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [TW-1:0] ERASE_LOAD   = TW'(ERASE_CYCLES - 1);
    localparam logic [TW-1:0] EXPOSE_LOAD  = TW'(EXPOSE_CYCLES - 1);
    localparam logic [TW-1:0] CONVERT_LOAD = TW'(CONVERT_CYCLES - 1);
    localparam logic [RW-1:0] LAST_ROW     = RW'(ROWS - 1);

    localparam logic [2:0] ST_IDLE    = 3'(S_IDLE);
    localparam logic [2:0] ST_ERASE   = 3'(S_ERASE);
    localparam logic [2:0] ST_EXPOSE  = 3'(S_EXPOSE);
    localparam logic [2:0] ST_CONVERT = 3'(S_CONVERT);
    localparam logic [2:0] ST_READ    = 3'(S_READ);

    logic [2:0]            state_q, state_d;
    logic                  erase_q, erase_d;
    logic                  expose_q, expose_d;
    logic                  ramp_q, ramp_d;
    logic [PIXEL_BITS-1:0] counter_q, counter_d;
    logic [ROWS-1:0]       row_sel_q, row_sel_d;
    logic [RW-1:0]         row_idx_q, row_idx_d;
    logic                  row_valid_q, row_valid_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    logic                  timer_load;
    logic [TW-1:0]         timer_value;
    logic                  timer_expired;

    pixel_sensor_phase_timer #(
        .WIDTH(TW)
    ) u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load),
        .load_value(timer_value),
        .expired   (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        timer_load   = 1'b0;
        timer_value  = '0;
        ramp_d       = 1'b0;
        counter_d    = counter_q;
        row_sel_d    = row_sel_q;
        row_idx_d    = row_idx_q;
        row_valid_d  = row_valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_ERASE;
                    timer_load  = 1'b1;
                    timer_value = ERASE_LOAD;
                    counter_d   = '0;
                end
            end
            ST_ERASE: begin
                if (timer_expired) begin
                    state_d     = ST_EXPOSE;
                    timer_load  = 1'b1;
                    timer_value = EXPOSE_LOAD;
                end
            end
            ST_EXPOSE: begin
                if (timer_expired) begin
                    state_d     = ST_CONVERT;
                    timer_load  = 1'b1;
                    timer_value = CONVERT_LOAD;
                end
            end
            ST_CONVERT: begin
                // The final cycle is always a RAMP-high cycle; leaving here keeps COUNTER at full scale.
                if (timer_expired) begin
                    state_d     = ST_READ;
                    row_sel_d   = ROWS'(1);
                    row_idx_d   = '0;
                    row_valid_d = 1'b1;
                end else begin
                    ramp_d = ~ramp_q;
                    if (ramp_q) begin
                        counter_d = counter_q + PIXEL_BITS'(1);
                    end
                end
            end
            ST_READ: begin
                if (row_valid_q && row_ready) begin
                    if (row_idx_q == LAST_ROW) begin
                        state_d      = ST_IDLE;
                        row_sel_d    = '0;
                        row_idx_d    = '0;
                        row_valid_d  = 1'b0;
                        frame_done_d = 1'b1;
                        counter_d    = '0;
                    end else begin
                        row_sel_d = row_sel_q << 1;
                        row_idx_d = row_idx_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                counter_d   = '0;
                row_sel_d   = '0;
                row_idx_d   = '0;
                row_valid_d = 1'b0;
            end
        endcase

        erase_d  = (state_d == ST_ERASE);
        expose_d = (state_d == ST_EXPOSE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            erase_q      <= 1'b0;
            expose_q     <= 1'b0;
            ramp_q       <= 1'b0;
            counter_q    <= '0;
            row_sel_q    <= '0;
            row_idx_q    <= '0;
            row_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            erase_q      <= erase_d;
            expose_q     <= expose_d;
            ramp_q       <= ramp_d;
            counter_q    <= counter_d;
            row_sel_q    <= row_sel_d;
            row_idx_q    <= row_idx_d;
            row_valid_q  <= row_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ERASE      = erase_q;
    assign EXPOSE     = expose_q;
    assign RAMP       = ramp_q;
    assign COUNTER    = counter_q;
    assign ROW_SEL    = row_sel_q;
    assign row_valid  = row_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
